// File: rtl/dmem_resp_bridge_pkg.sv
// Shared definitions for the data-memory response bridge: bus widths, FSM
// state encoding, access size codes, the default physical address mask and
// the packed request payload carried from issue to the sram-like bus.
package dmem_resp_bridge_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned SIZE_W = 2;

  // Strips the kseg bits so the bus sees a physical address
  localparam logic [ADDR_W-1:0] PADDR_MASK_DEFAULT = 32'h1FFF_FFFF;

  // Access size codes shared by the CPU side and the bus side
  localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'd0;
  localparam logic [SIZE_W-1:0] SIZE_HALF = 2'd1;
  localparam logic [SIZE_W-1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } dmemState_e;

  // Request payload latched when the FSM leaves IDLE
  typedef struct packed {
    logic              wr;
    logic [SIZE_W-1:0] size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } busPayload_t;

endpackage

// File: rtl/dmem_wbuf.sv
// Single-entry posted write buffer occupancy tracker.
// The entry's payload lives in the bridge's bus payload registers, which are
// held stable until the drain completes, so only the valid flag is kept here.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (invalidates the entry)
//   push      - a store is posted into the buffer
//   pop       - the drain's write-complete response was seen
//   valid     - buffer holds an undrained store
module dmem_wbuf
  import dmem_resp_bridge_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  output logic valid
);

  // Push happens only from IDLE and pop only from REQ/DATA, so they never collide
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (push) begin
      valid <= 1'b1;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dmem_resp_bridge.sv
// Bridges the CPU M-stage data access onto a single-outstanding sram-like bus
// and raises a stall request until the access has been answered.
// Optional feature: define DMEM_WBUF_EN to post stores into a one-entry write
// buffer so they retire without stalling; otherwise stores block like loads.
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   cpu_en/wen/size/addr/wdata       - M-stage access request
//   cpu_except                       - M-stage exception, blocks new issue
//   cpu_rdata                        - load data, valid when stallreq falls
//   stallreq                         - stall request to the hazard unit
//   bus_req/wr/size/addr/wdata       - bus request and payload
//   bus_addr_ok/data_ok/rdata        - bus accept, response and read data
module dmem_resp_bridge
  import dmem_resp_bridge_pkg::*;
#(
  parameter logic [ADDR_W-1:0] PADDR_MASK = PADDR_MASK_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_en,
  input  logic [STRB_W-1:0] cpu_wen,
  input  logic [SIZE_W-1:0] cpu_size,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_except,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              stallreq,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [SIZE_W-1:0] bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata
);

  dmemState_e  stateQ;
  dmemState_e  stateD;
  busPayload_t payloadQ;
  logic [DATA_W-1:0] rdataQ;

  logic cpuReq;
  logic isStore;
  logic issue;
  logic dataAccept;
  logic postNow;   // current IDLE issue is a posted store
  logic posted;    // transaction in flight is a posted-store drain

  assign cpuReq  = cpu_en & ~cpu_except;
  assign isStore = |cpu_wen;

`ifdef DMEM_WBUF_EN
  logic wbufValid;

  assign postNow = isStore & ~wbufValid;

  dmem_wbuf u_wbuf (
    .clk   (clk),
    .rst   (rst),
    .push  (issue & postNow),
    .pop   (dataAccept & posted),
    .valid (wbufValid)
  );
`else
  assign postNow = 1'b0;
  assign posted  = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= ST_IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  // Next-state logic; a data_ok without a prior/simultaneous addr_ok is ignored
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      ST_IDLE: if (cpuReq) stateD = ST_REQ;
      ST_REQ:  if (bus_addr_ok) stateD = bus_data_ok ? ST_DONE : ST_DATA;
      ST_DATA: if (bus_data_ok) stateD = ST_DONE;
      ST_DONE: stateD = ST_IDLE;
      default: stateD = ST_IDLE;
    endcase
  end

  // Output / control decode. During a posted drain the CPU only stalls if it
  // presents a new access, which must wait for the single bus slot.
  always_comb begin
    stallreq   = 1'b0;
    bus_req    = 1'b0;
    issue      = 1'b0;
    dataAccept = 1'b0;
    case (stateQ)
      ST_IDLE: begin
        issue    = cpuReq;
        stallreq = cpuReq & ~postNow;
      end
      ST_REQ: begin
        bus_req    = 1'b1;
        dataAccept = bus_addr_ok & bus_data_ok;
        stallreq   = posted ? cpuReq : 1'b1;
      end
      ST_DATA: begin
        dataAccept = bus_data_ok;
        stallreq   = posted ? cpuReq : 1'b1;
      end
      ST_DONE: begin
        stallreq = posted ? cpuReq : 1'b0;
      end
      default: ;
    endcase
    if (rst) begin
      stallreq = 1'b0;
      bus_req  = 1'b0;
    end
  end

  // Issue payload and load-data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      payloadQ <= '0;
      rdataQ   <= '0;
`ifdef DMEM_WBUF_EN
      posted   <= 1'b0;
`endif
    end else begin
      if (issue) begin
        payloadQ <= '{wr: isStore, size: cpu_size,
                      addr: cpu_addr & PADDR_MASK, wdata: cpu_wdata};
`ifdef DMEM_WBUF_EN
        posted   <= postNow;
`endif
      end
      if (dataAccept && !payloadQ.wr) begin
        rdataQ <= bus_rdata;
      end
    end
  end

  assign cpu_rdata = rdataQ;
  assign bus_wr    = payloadQ.wr;
  assign bus_size  = payloadQ.size;
  assign bus_addr  = payloadQ.addr;
  assign bus_wdata = payloadQ.wdata;

endmodule

// File: tb/tb_dmem_resp_bridge.sv
// Scoreboard bench for dmem_resp_bridge: a bus slave with random latencies and
// its own memory, a CPU-side driver with a program-order reference memory, and
// a monitor that checks bus payloads and load results as they appear.
module tb_dmem_resp_bridge;
  import dmem_resp_bridge_pkg::*;

  localparam logic [31:0] MASK = 32'h1FFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_en, cpu_except;
  logic [3:0]  cpu_wen;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        stallreq, bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_addr_ok, bus_data_ok;

  dmem_resp_bridge dut (
    .clk(clk), .rst(rst),
    .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_except(cpu_except), .cpu_rdata(cpu_rdata),
    .stallreq(stallreq), .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } reqT;
  typedef struct {
    bit          isLoad;
    logic [31:0] data;
  } doneT;

  reqT  expReq[$];
  doneT expDone[$];
  int   aDlyQ[$];
  int   sDlyQ[$];
  logic [31:0] refMem[int];
  logic [31:0] slaveMem[int];

  int   checks = 0;
  int   errors = 0;
  int   fA = -1;
  int   fD = -1;
  bit   slaveEn = 1'b1;
  int   reqCycles = 0;
  doneT monD;
  logic        sWr;
  logic [1:0]  sSize;
  logic [31:0] sAddr, sWdata;

  function automatic logic [31:0] initWord(int idx);
    return 32'h5A00_0000 ^ (32'(idx) * 32'h0001_0203);
  endfunction

  function automatic logic [31:0] refRead(int idx);
    if (refMem.exists(idx)) return refMem[idx];
    return initWord(idx);
  endfunction

  function automatic logic [31:0] slaveRead(int idx);
    if (slaveMem.exists(idx)) return slaveMem[idx];
    return initWord(idx);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic finishNow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  initial begin
    #300000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    finishNow();
  end

  // Bus slave: applies writes by size/address lanes, answers reads from its memory
  task automatic slaveRespond();
    logic [31:0] m;
    int idx;
    bus_data_ok = 1'b1;
    idx = int'(sAddr >> 2);
    if (sWr) begin
      case (sSize)
        2'd0:    m = 32'h0000_00FF << {sAddr[1:0], 3'b000};
        2'd1:    m = 32'h0000_FFFF << {sAddr[1:0], 3'b000};
        default: m = 32'hFFFF_FFFF;
      endcase
      slaveMem[idx] = (slaveRead(idx) & ~m) | (sWdata & m);
    end else begin
      bus_rdata = slaveRead(idx);
    end
  endtask

  initial begin
    int a, d;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (slaveEn && bus_req && !rst) begin
        a = (fA < 0) ? int'($urandom_range(0, 4)) : fA;
        d = (fD < 0) ? int'($urandom_range(0, 3)) : fD;
        sAddr = bus_addr; sWr = bus_wr; sSize = bus_size; sWdata = bus_wdata;
        aDlyQ.push_back(a);
`ifndef DMEM_WBUF_EN
        sDlyQ.push_back(a + d);
`endif
        repeat (a) begin @(posedge clk); #1; end
        bus_addr_ok = 1'b1;
        if (d == 0) slaveRespond();
        @(posedge clk); #1;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = $urandom;
        if (d > 0) begin
          repeat (d - 1) begin @(posedge clk); #1; end
          slaveRespond();
          @(posedge clk); #1;
          bus_data_ok = 1'b0;
          bus_rdata   = $urandom;
        end
      end
    end
  end

  // Monitor: bus payload scoreboard, request length, exception stall, load result
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_req) begin
        reqCycles++;
        if (expReq.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_bus_req: got bus_req=1 expected 0");
        end else begin
          chk("bus_addr", bus_addr, expReq[0].addr);
          chk("bus_wr", 32'(bus_wr), 32'(expReq[0].wr));
          chk("bus_size", 32'(bus_size), 32'(expReq[0].size));
          chk("bus_wdata", bus_wdata, expReq[0].wdata);
          if (bus_addr_ok) begin
            void'(expReq.pop_front());
            if (aDlyQ.size() > 0) chk("bus_req_cycles", 32'(reqCycles), 32'(aDlyQ.pop_front() + 1));
            reqCycles = 0;
          end
        end
      end
      if (cpu_en && cpu_except) chk("stall_on_except", 32'(stallreq), 32'd0);
      if (cpu_en && !cpu_except && !stallreq) begin
        if (expDone.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_completion: got stallreq=0 with no access pending");
        end else begin
          monD = expDone.pop_front();
          if (monD.isLoad) chk("cpu_rdata", cpu_rdata, monD.data);
        end
      end
    end
  end

  task automatic doOp(input bit isLoad, input logic [31:0] addr, input logic [1:0] size,
                      input logic [3:0] wen, input logic [31:0] wdata, output int stalls);
    int idx;
    logic [31:0] w;
    cpu_en = 1'b1; cpu_except = 1'b0; cpu_addr = addr; cpu_size = size;
    cpu_wen = isLoad ? 4'h0 : wen; cpu_wdata = wdata;
    idx = int'((addr & MASK) >> 2);
    expReq.push_back('{!isLoad, size, addr & MASK, wdata});
    if (isLoad) begin
      expDone.push_back('{1'b1, refRead(idx)});
    end else begin
      expDone.push_back('{1'b0, 32'h0});
      w = refRead(idx);
      for (int b = 0; b < 4; b++) if (wen[b]) w[b*8 +: 8] = wdata[b*8 +: 8];
      refMem[idx] = w;
    end
    stalls = 0;
    while (1) begin
      @(negedge clk);
      if (!stallreq) break;
      stalls++;
      if (stalls > 100) begin
        errors++;
        $display("FAIL op_timeout: stallreq still 1 after %0d cycles", stalls);
        finishNow();
      end
    end
    @(posedge clk); #1;
    cpu_en = 1'b0; cpu_wen = 4'h0;
  endtask

  // Blocking-access stall length follows from the slave's chosen latencies
  task automatic stallCheck(input int stalls);
`ifndef DMEM_WBUF_EN
    if (sDlyQ.size() > 0) chk("stall_cycles", 32'(stalls), 32'(2 + sDlyQ.pop_front()));
`else
    if (stalls < 0) chk("stall_cycles", 32'(stalls), 32'd0);
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int st, st2, r, idx, off;
    logic [1:0]  sz;
    logic [3:0]  wen;
    logic [31:0] addr;

    rst = 1'b1; cpu_en = 1'b0; cpu_except = 1'b0; cpu_wen = 4'h0;
    cpu_size = 2'd0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_stallreq", 32'(stallreq), 32'd0);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_wr", 32'(bus_wr), 32'd0);
    chk("rst_bus_size", 32'(bus_size), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    @(posedge clk); #1;

    // Minimum-latency load through a kseg address
    slaveMem[4] = 32'hDEAD_BEEF;
    refMem[4]   = 32'hDEAD_BEEF;
    fA = 0; fD = 0;
    doOp(1'b1, 32'h8000_0010, SIZE_WORD, 4'h0, 32'h0, st);
    chk("min_load_stall", 32'(st), 32'd2);
    stallCheck(st);
    chk("rdata_hold", cpu_rdata, 32'hDEAD_BEEF);

    // Slow address accept
    fA = 4; fD = 0;
    doOp(1'b1, 32'h2000_0024, SIZE_WORD, 4'h0, 32'h0, st);
    chk("slow_accept_stall", 32'(st), 32'd6);
    stallCheck(st);

    // Halfword store
    fA = 0; fD = 1;
    doOp(1'b0, 32'h0000_0020, SIZE_HALF, 4'b0011, 32'h0000_1234, st);
`ifdef DMEM_WBUF_EN
    chk("half_store_stall", 32'(st), 32'd0);
`else
    chk("half_store_stall", 32'(st), 32'd3);
`endif
    stallCheck(st);
    idle(4);

    // Store immediately followed by a load of the same word
    fA = 0; fD = 0;
    doOp(1'b0, 32'h0000_0030, SIZE_WORD, 4'hF, 32'hA5A5_0001, st);
    doOp(1'b1, 32'h0000_0030, SIZE_WORD, 4'h0, 32'h0, st2);
`ifdef DMEM_WBUF_EN
    chk("posted_store_stall", 32'(st), 32'd0);
    chk("load_behind_drain_stall", 32'(st2), 32'd4);
`else
    chk("blocking_store_stall", 32'(st), 32'd2);
    chk("load_after_store_stall", 32'(st2), 32'd2);
    stallCheck(st);
    stallCheck(st2);
`endif
    idle(4);

    // Exception in IDLE blocks issue
    cpu_en = 1'b1; cpu_except = 1'b1; cpu_addr = 32'h0000_0044; cpu_size = SIZE_WORD;
    cpu_wen = 4'h0;
    repeat (3) begin
      @(negedge clk);
      chk("except_no_bus_req", 32'(bus_req), 32'd0);
    end
    @(posedge clk); #1;
    cpu_en = 1'b0; cpu_except = 1'b0;
    idle(2);

    // Reset while waiting for data, then a stray response
    slaveEn = 1'b0;
    cpu_en = 1'b1; cpu_addr = 32'h4000_0040; cpu_size = SIZE_WORD; cpu_wen = 4'h0;
    cpu_wdata = 32'h1111_2222;
    expReq.push_back('{1'b0, SIZE_WORD, 32'h0000_0040, 32'h1111_2222});
    aDlyQ.push_back(0);
    @(posedge clk); #1;
    bus_addr_ok = 1'b1;
    @(posedge clk); #1;
    bus_addr_ok = 1'b0;
    rst = 1'b1; cpu_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    bus_data_ok = 1'b1; bus_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("rst_mid_stallreq", 32'(stallreq), 32'd0);
    chk("rst_mid_bus_req", 32'(bus_req), 32'd0);
    chk("rst_mid_rdata", cpu_rdata, 32'd0);
    @(posedge clk); #1;
    bus_data_ok = 1'b0;
    @(negedge clk);
    chk("stray_data_ok_rdata", cpu_rdata, 32'd0);
    chk("stray_data_ok_stall", 32'(stallreq), 32'd0);
    @(posedge clk); #1;
    slaveEn = 1'b1;

    // Random traffic
    fA = -1; fD = -1;
    for (int n = 0; n < 150; n++) begin
      r   = int'($urandom_range(0, 9));
      idx = int'($urandom_range(0, 15));
      sz  = 2'($urandom_range(0, 2));
      case (sz)
        2'd0:    begin off = int'($urandom_range(0, 3));     wen = 4'(4'b0001 << off); end
        2'd1:    begin off = 2 * int'($urandom_range(0, 1)); wen = 4'(4'b0011 << off); end
        default: begin off = 0;                              wen = 4'hF; end
      endcase
      addr = ($urandom & 32'hE000_0000) | 32'(idx << 2) | 32'(off);
      if (r == 0) begin
        cpu_en = 1'b1; cpu_except = 1'b1; cpu_addr = addr; cpu_wen = wen;
        @(negedge clk);
        @(posedge clk); #1;
        cpu_en = 1'b0; cpu_except = 1'b0; cpu_wen = 4'h0;
      end else if (r <= 4) begin
        doOp(1'b1, addr, sz, 4'h0, $urandom, st);
        stallCheck(st);
      end else if (r <= 8) begin
        doOp(1'b0, addr, sz, wen, $urandom, st);
        stallCheck(st);
      end else begin
        idle(1);
      end
    end

    idle(12);
    chk("exp_req_drained", 32'(expReq.size()), 32'd0);
    chk("exp_done_drained", 32'(expDone.size()), 32'd0);
    finishNow();
  end

endmodule
